pc_seq: RTL
===========

Name: pc_seq

Overview:
Fetch-stage PC sequencer for the 5-stage MIPS pipeline. Owns the F-stage PC register and selects the next PC: sequential, branch, j/jal, jr-style register targets, exception vector or eret return. It also applies hazard-unit stalls, keeps the EPC register, and flags F/D flushes on control redirects.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_VEC, 32'h0000_4180, exception handler entry address
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard-unit stall; hold PC, no fetch advance
pcsrc  in  3  D-stage next-PC select (NPC_PC4/NPC_B/NPC_JAL/NPC_RS/NPC_RT)
judge  in  1  D-stage branch condition result
e32_d  in  32  D-stage sign-extended, pre-shifted branch offset
instr_idx  in  26  D-stage instr[25:0] for j/jal
v1  in  32  forwarded rs value
v2  in  32  forwarded rt value
exc_req  in  1  exception taken this cycle (from M stage)
epc_in  in  32  victim PC to record on exception
eret_req  in  1  eret committed this cycle
pc_f  out  32  current fetch PC
epc  out  32  exception PC register
fetch_valid  out  1  fetched instruction is valid (0 = bubble)
redirect  out  1  control redirect taken this cycle
exc_flush  out  1  exception/eret flush to all younger stages
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async, immediate): pc_f=RESET_PC, epc=0, state=RUN, fetch_valid=0, redirect=0, exc_flush=0, stall_cnt=0. First rising edge after reset deassert: state RUN, fetch_valid=1.
- Combinational target: pc4=pc_f+4. B: judge ? pc_f+e32_d : pc4. JAL: {pc_f[31:28],instr_idx,2'b00}. RS: v1. RT: v2. Any other pcsrc: pc4. All arithmetic is 32-bit and wraps modulo 2^32.
- Per-edge priority: exc_req > eret_req > stall > normal.
- exc_req: pc_f<=EXC_VEC, epc<=epc_in, state->FLUSH. The exception overrides stall.
- eret_req (no exc_req): pc_f<=epc, state->FLUSH. epc unchanged.
- stall (no exc/eret): pc_f held, state->HOLD, stall_cnt+=1, saturating at all ones.
- Normal: pc_f<=npc, state->RUN.
- States:
  RUN: fetch_valid=1.
  HOLD: fetch_valid=1 (the held instruction is re-presented).
  FLUSH: exactly one cycle, fetch_valid=0, exc_flush=1. Next edge goes to RUN, or to HOLD if stall is high; exc_req still takes priority.
- redirect is combinational: 1 when state!=FLUSH, stall=0, and (pcsrc∈{JAL,RS,RT}, or pcsrc==B with judge=1). Not-taken branches give redirect=0.
- exc_req and eret_req in the same cycle: the exception wins; eret is dropped.
- Unaligned targets (v1/v2 low bits !=0) are loaded as-is. Alignment faults are raised downstream, not here.

Decomposition:
- Shared header constants: NPC_PC4=3'd0, NPC_B=3'd1, NPC_JAL=3'd2, NPC_RS=3'd3, NPC_RT=3'd4; state encodings RUN=2'd0, HOLD=2'd1, FLUSH=2'd2; RESET_PC and EXC_VEC defaults.
- One sub-module, npc_sel: the purely combinational target mux (pc_f, pcsrc, judge, e32_d, instr_idx, v1, v2 → npc).
- pc_seq holds the PC/EPC registers, the FSM and the counter.

Test Plan:
- Reset mid-run with pc_f=0x3010 → pc_f=0x3000 immediately (no edge needed), stall_cnt=0, fetch_valid=0; after release, pc_f goes 0x3000→0x3004→0x3008.
- pcsrc=B, judge=1, pc_f=0x3008, e32_d=0xFFFF_FFF8 → next pc_f=0x3000, redirect=1. With judge=0 → pc_f=0x300C, redirect=0.
- pcsrc=JAL, pc_f=0x3004, instr_idx=0x0000C40 → pc_f=0x0000_3100. pcsrc=RS with v1=0x3200 → pc_f=0x3200.
- stall held 3 cycles at pc_f=0x3010 → pc_f stays 0x3010, stall_cnt=3, state HOLD; stall_cnt saturates at 0xFFFF.
- exc_req with stall=1, epc_in=0x3020 → pc_f=0x4180, epc=0x3020, one cycle fetch_valid=0/exc_flush=1; then eret_req → pc_f=0x3020.
- exc_req and eret_req together → pc_f=0x4180, epc updated; the eret has no effect.

Source files
------------

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared next-PC select codes, FSM states and address defaults
//               for the fetch-stage PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_B   = 3'd1;
    localparam logic [2:0] NPC_JAL = 3'd2;
    localparam logic [2:0] NPC_RS  = 3'd3;
    localparam logic [2:0] NPC_RT  = 3'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;
    localparam int          CNT_W_DEFAULT    = 16;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/pc_seq_npc_sel.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_npc_sel
// Description : Combinational next-PC target mux driven by the D-stage select.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_npc_sel
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc_f,
    input  logic [2:0]  pcsrc,
    input  logic        judge,
    input  logic [31:0] e32_d,
    input  logic [25:0] instr_idx,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    output logic [31:0] npc
);

    logic [31:0] pc4;

    assign pc4 = pc_f + 32'd4;

    always_comb begin
        npc = pc4;
        case (pcsrc)
            NPC_B:   npc = judge ? (pc_f + e32_d) : pc4;
            NPC_JAL: npc = {pc_f[31:28], instr_idx, 2'b00};
            NPC_RS:  npc = v1;
            NPC_RT:  npc = v2;
            default: npc = pc4;
        endcase
    end

endmodule : pc_seq_npc_sel
`default_nettype wire

// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq
// Description : Fetch-stage PC register, EPC, redirect/flush FSM and
//               saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT,
    parameter int          CNT_W    = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       pcsrc,
    input  logic             judge,
    input  logic [31:0]      e32_d,
    input  logic [25:0]      instr_idx,
    input  logic [31:0]      v1,
    input  logic [31:0]      v2,
    input  logic             exc_req,
    input  logic [31:0]      epc_in,
    input  logic             eret_req,
    output logic [31:0]      pc_f,
    output logic [31:0]      epc,
    output logic             fetch_valid,
    output logic             redirect,
    output logic             exc_flush,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      epc_q, epc_d;
    state_e           state_q, state_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             exc_flush_q, exc_flush_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]      npc;

    pc_seq_npc_sel u_npc_sel (
        .pc_f      (pc_q),
        .pcsrc     (pcsrc),
        .judge     (judge),
        .e32_d     (e32_d),
        .instr_idx (instr_idx),
        .v1        (v1),
        .v2        (v2),
        .npc       (npc)
    );

    // Exception beats eret beats stall beats normal sequencing.
    always_comb begin
        pc_d        = pc_q;
        epc_d       = epc_q;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (exc_req) begin
            pc_d    = EXC_VEC;
            epc_d   = epc_in;
            state_d = FLUSH;
        end else if (eret_req) begin
            pc_d    = epc_q;
            state_d = FLUSH;
        end else if (stall) begin
            state_d = HOLD;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            pc_d    = npc;
            state_d = RUN;
        end
        fetch_valid_d = (state_d != FLUSH);
        exc_flush_d   = (state_d == FLUSH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            epc_q         <= 32'd0;
            state_q       <= RUN;
            fetch_valid_q <= 1'b0;
            exc_flush_q   <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            exc_flush_q   <= exc_flush_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign redirect = (state_q != FLUSH) && !stall &&
                      ((pcsrc == NPC_JAL) || (pcsrc == NPC_RS) || (pcsrc == NPC_RT) ||
                       ((pcsrc == NPC_B) && judge));

    assign pc_f        = pc_q;
    assign epc         = epc_q;
    assign fetch_valid = fetch_valid_q;
    assign exc_flush   = exc_flush_q;
    assign stall_cnt   = stall_cnt_q;

endmodule : pc_seq
`default_nettype wire
